// File: rtl/edge_packer_pkg.sv
// Shared definitions for the edge packer slice.
//   edge_pix()        : valid edge bits per frame, (hor-2)*(vert-2)
//   words_per_frame() : packed words per frame, ceil(edge_pix/word_w)
//   fifo_entry_t      : word FIFO record {addr, data, last} at default widths
//   ctrl_state_e      : write-request control states
package edge_packer_pkg;

    localparam int unsigned DEF_WORD_W = 16;
    localparam int unsigned DEF_ADDR_W = 11;

    function automatic int unsigned edge_pix(input int unsigned hor, input int unsigned vert);
        return (hor - 2) * (vert - 2);
    endfunction

    function automatic int unsigned words_per_frame(input int unsigned hor,
                                                    input int unsigned vert,
                                                    input int unsigned word_w);
        return (edge_pix(hor, vert) + word_w - 1) / word_w;
    endfunction

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_WORD_W-1:0] data;
        logic                  last;
    } fifo_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/edge_packer_word_fifo2.sv
// Two-entry word FIFO. Slot 0 is always the head, so head is a plain register.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (dropped when full and not popping)
//   pop       : remove head (ignored when empty)
//   full      : two entries held
//   empty     : no entries held
//   head      : oldest entry
module word_fifo2
    import edge_packer_pkg::*;
#(
    parameter type entry_t = fifo_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push = push && ((count_q != 2'd2) || do_pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (do_pop) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
        if (do_push) begin
            if (count_d == 2'd0) begin
                slot0_d = push_data;
            end else begin
                slot1_d = push_data;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = slot0_q;

endmodule

// File: rtl/edge_packer.sv
// Packs a stream of binary edge pixels LSB-first into WORD_W-bit words and
// writes them to memory through a 2-entry FIFO with a valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   edge_bit, edge_valid : edge pixel stream, no backpressure
//   wr_en, wr_ready      : write request / accept
//   wr_addr, wr_data     : word address and packed data of the request
//   frame_done           : one-cycle pulse after the last word of a frame is accepted
//   overflow             : sticky, a word was dropped on a full FIFO
module edge_packer
    import edge_packer_pkg::*;
#(
    parameter int unsigned HOR_PIC  = 160,
    parameter int unsigned VERT_PIC = 160,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              edge_bit,
    input  logic              edge_valid,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned FRAME_BITS = edge_pix(HOR_PIC, VERT_PIC);
    localparam int unsigned LAST_ADDR  = words_per_frame(HOR_PIC, VERT_PIC, WORD_W) - 1;
    localparam int unsigned CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned IDX_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              last;
    } entry_t;

    ctrl_state_e       state_q, state_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [WORD_W-1:0] word_bits;
    logic              word_end;
    logic              frame_end;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    word_fifo2 #(
        .entry_t(entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Packing datapath.
    always_comb begin
        word_bits            = pack_q;
        word_bits[bit_idx_q] = edge_bit;
        word_end             = (bit_idx_q == IDX_W'(WORD_W - 1));
        frame_end            = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
        pack_d               = pack_q;
        bit_idx_d            = bit_idx_q;
        bit_cnt_d            = bit_cnt_q;
        addr_d               = addr_q;
        push                 = 1'b0;
        push_entry           = '0;
        if (edge_valid) begin
            if (word_end || frame_end) begin
                push            = 1'b1;
                push_entry.addr = addr_q;
                push_entry.data = word_bits;
                push_entry.last = frame_end;
                pack_d          = '0;
                bit_idx_d       = '0;
                bit_cnt_d       = frame_end ? '0 : bit_cnt_q + CNT_W'(1);
                // Counters advance even when the FIFO drops this word.
                addr_d          = (frame_end || addr_q == ADDR_W'(LAST_ADDR)) ? '0
                                                                              : addr_q + ADDR_W'(1);
            end else begin
                pack_d    = word_bits;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Write-request control.
    always_comb begin
        pop          = (state_q == REQ) && wr_ready && !fifo_empty;
        state_d      = state_q;
        case (state_q)
            IDLE: if (push) state_d = REQ;
            REQ:  if (pop && !push && !fifo_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_en_d      = (state_d == REQ);
        frame_done_d = pop && fifo_head.last;
        overflow_d   = overflow_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pack_q       <= '0;
            bit_idx_q    <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_q       <= pack_d;
            bit_idx_q    <= bit_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = fifo_head.addr;
    assign wr_data    = fifo_head.data;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_packer.sv
// Bench for edge_packer: bit-level reference model feeding an expected-write
// scoreboard, checked by an independent negedge monitor.
module tb_edge_packer;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned FRAME_BITS = 158 * 158;
    localparam int unsigned FRAME_WORDS = (FRAME_BITS + WORD_W - 1) / WORD_W;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              edge_bit   = 1'b0;
    logic              edge_valid = 1'b0;
    logic              wr_ready   = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              frame_done;
    logic              overflow;

    edge_packer #(
        .HOR_PIC (160),
        .VERT_PIC(160),
        .WORD_W  (WORD_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .edge_bit  (edge_bit),
        .edge_valid(edge_valid),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        bit          last;
    } word_t;

    word_t       exp_q[$];
    word_t       acc_log[$];
    int unsigned last_data_q[$];

    int          m_level = 0;
    bit          m_ovf   = 1'b0;
    int unsigned m_n     = 0;
    int unsigned m_cur   = 0;

    int checks    = 0;
    int failures  = 0;
    bit mon_on    = 1'b0;
    bit fd_exp    = 1'b0;
    int fd_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bit n lands in word n/WORD_W at bit n%WORD_W.
    // Queue depth is tracked as an occupancy number against a capacity of 2.
    task automatic model_step();
        word_t w;
        if (rst) begin
            exp_q.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_n     = 0;
            m_cur   = 0;
            return;
        end
        if (m_level > 0 && wr_ready) m_level--;
        if (edge_valid) begin
            if (edge_bit) m_cur |= 32'd1 << (m_n % WORD_W);
            m_n++;
            if ((m_n % WORD_W) == 0 || m_n == FRAME_BITS) begin
                w.addr = (m_n - 1) / WORD_W;
                w.data = m_cur;
                w.last = (m_n == FRAME_BITS);
                if (m_level == 2) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_q.push_back(w);
                    m_level++;
                end
                m_cur = 0;
                if (w.last) m_n = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic r);
        edge_valid = v;
        edge_bit   = b;
        wr_ready   = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: checks presented requests against the scoreboard head.
    always @(negedge clk) begin
        word_t w;
        if (mon_on) begin
            chk("wr_en", wr_en, m_level > 0);
            chk("overflow", overflow, m_ovf);
            chk("frame_done", frame_done, fd_exp);
            if (frame_done === 1'b1) fd_pulses++;
            fd_exp = 1'b0;
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%0h data=%0h expected none at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    chk("wr_addr", wr_addr, exp_q[0].addr);
                    chk("wr_data", wr_data, exp_q[0].data);
                    if (wr_ready && !rst) begin
                        w = exp_q.pop_front();
                        acc_log.push_back(w);
                        if (w.last) begin
                            fd_exp = 1'b1;
                            last_data_q.push_back(w.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int fd_base;

        do_reset();
        do_reset();
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_overflow", overflow, 0);
        cycle(1'b0, 1'b0, 1'b0);

        // Alternating 1,0,... packs to 16'h5555 at address 0.
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, (i % 2) == 0, 1'b1);
        drain(3);
        chk("alt_count", acc_log.size(), 1);
        if (acc_log.size() > 0) begin
            chk("alt_addr", acc_log[0].addr, 0);
            chk("alt_data", acc_log[0].data, 16'h5555);
        end
        chk("alt_overflow", overflow, 0);

        // Stall: two words held, third dropped, address keeps advancing.
        do_reset();
        acc_log.delete();
        repeat (8)  cycle(1'b1, 1'($urandom % 2), 1'b1);
        repeat (40) cycle(1'b1, 1'($urandom % 2), 1'b0);
        chk("stall_overflow_set", overflow, 1);
        repeat (20) cycle(1'b1, 1'($urandom % 2), 1'b1);
        drain(3);
        chk("stall_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("stall_addr0", acc_log[0].addr, 0);
            chk("stall_addr1", acc_log[1].addr, 1);
            chk("stall_addr_skip", acc_log[2].addr, 3);
        end
        chk("stall_overflow_sticky", overflow, 1);

        // Sparse valid with toggling ready: no loss, addresses in order.
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 256; i++) cycle(1'((i % 2) == 0), 1'($urandom % 2), 1'(((i / 3) % 2) == 0));
        drain(4);
        chk("sparse_overflow", overflow, 0);
        chk("sparse_count", acc_log.size(), 8);
        foreach (acc_log[k]) chk("sparse_addr_order", acc_log[k].addr, k);

        // Reset mid-frame discards queued and partial words.
        do_reset();
        repeat (100) cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2));
        do_reset();
        acc_log.delete();
        repeat (16) cycle(1'b1, 1'b1, 1'b1);
        drain(3);
        chk("midrst_count", acc_log.size(), 1);
        if (acc_log.size() > 0) begin
            chk("midrst_addr", acc_log[0].addr, 0);
            chk("midrst_data", acc_log[0].data, 16'hFFFF);
        end

        // Random traffic, overflow allowed.
        do_reset();
        repeat (600) cycle(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) != 0));
        drain(4);

        // Two back-to-back full frames at full throughput.
        do_reset();
        acc_log.delete();
        last_data_q.delete();
        fd_base = fd_pulses;
        for (int i = 0; i < int'(FRAME_BITS); i++) cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < int'(FRAME_BITS); i++) cycle(1'b1, 1'($urandom % 2), 1'b1);
        drain(4);
        chk("frames_done_pulses", fd_pulses - fd_base, 2);
        chk("frames_word_count", acc_log.size(), 2 * FRAME_WORDS);
        chk("frames_last_count", last_data_q.size(), 2);
        if (last_data_q.size() > 0) chk("frame1_last_data", last_data_q[0], 16'h000F);
        if (acc_log.size() == 2 * FRAME_WORDS) begin
            chk("frame1_last_addr", acc_log[FRAME_WORDS-1].addr, 1560);
            chk("frame2_first_addr", acc_log[FRAME_WORDS].addr, 0);
            chk("frame2_last_addr", acc_log[2*FRAME_WORDS-1].addr, 1560);
        end
        chk("frames_overflow", overflow, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_packer.md
EDGE_PACKER -- requirements
Module: edge_packer

Interface
REQ-001 Parameter HOR_PIC, default 160: input picture width in pixels.
REQ-002 Parameter VERT_PIC, default 160: input picture height in pixels.
REQ-003 Parameter WORD_W, default 16: packed word width in bits.
REQ-004 Parameter ADDR_W, default 11: word address width; 2^ADDR_W SHALL be at least ceil(EDGE_PIX/WORD_W).
REQ-005 Derived constant EDGE_PIX = (HOR_PIC-2)*(VERT_PIC-2): valid edge bits per frame, 24964 at defaults.
REQ-006 Ports:
- clk, input, 1: sole clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- edge_bit, input, 1: binary edge pixel from the upstream Sobel stage.
- edge_valid, input, 1: qualifies edge_bit; there is no backpressure to upstream.
- wr_en, output, 1: memory write request, held until accepted.
- wr_ready, input, 1: memory accepts the word in a cycle where wr_en and wr_ready are both 1.
- wr_addr, output, ADDR_W: word address of the current request.
- wr_data, output, WORD_W: packed word of the current request.
- frame_done, output, 1: one-cycle pulse when the last word of a frame is accepted.
- overflow, output, 1: sticky flag indicating that data was lost.

Function
REQ-007 Each cycle with edge_valid=1 SHALL shift edge_bit into the pack register, first bit of the word at bit 0 (LSB-first), and increment the bit counter.
REQ-008 When WORD_W bits are collected, the word SHALL be pushed into a 2-entry word FIFO in the same cycle the last bit arrives. Each FIFO entry holds {addr, data, last}.
REQ-009 When the frame bit counter reaches EDGE_PIX, the partial word SHALL be pushed with its unused upper bits zero and last=1. At defaults this is word 1560 with 4 valid bits.
REQ-010 After a last push:
- the bit counter and word address SHALL return to 0;
- the next edge_valid bit SHALL begin a new frame at address 0.
REQ-011 The word address SHALL increment by 1 per push and SHALL never exceed ceil(EDGE_PIX/WORD_W)-1.
REQ-012 wr_en, wr_addr and wr_data SHALL present the FIFO head whenever the FIFO is non-empty, registered.
REQ-013 The FIFO head SHALL pop when wr_en and wr_ready are both 1.
REQ-014 While wr_en=1 and wr_ready=0, wr_addr and wr_data SHALL hold stable.
REQ-015 Push and pop in the same cycle SHALL both occur. The FIFO level SHALL stay unchanged, and a full FIFO SHALL accept the push.
REQ-016 A push into a full FIFO with no pop SHALL:
- discard the new word;
- set overflow to 1, which stays set until rst;
- still advance the address and bit counters.
REQ-017 frame_done SHALL be 1 for exactly the cycle after the accept of an entry with last=1.
REQ-018 Minimum latency from the last bit of a word to wr_en=1 SHALL be 1 cycle.
REQ-019 Sustained throughput SHALL be one word per cycle when wr_ready=1.
REQ-020 edge_valid=0 SHALL leave the pack register and bit counter unchanged; gaps of any length are legal.

Reset
REQ-021 While rst=1 on a rising clk edge, the following SHALL be cleared:
- wr_en=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0;
- FIFO empty, bit counter=0, pack register=0.
REQ-022 Reset mid-frame SHALL discard the partial word and the queued words, and the next valid bit SHALL be bit 0 of address 0.
REQ-023 Inputs SHALL be ignored in the cycle rst=1.

Structure
REQ-024 A shared package SHALL hold:
- the EDGE_PIX expression;
- the words-per-frame constant ceil(EDGE_PIX/WORD_W);
- the FIFO entry record type {addr, data, last}.
REQ-025 The 2-entry FIFO SHALL be a sub-module named word_fifo2, with push, pop, full, empty and head outputs.
REQ-026 Control SHALL be a two-state machine: IDLE (FIFO empty, wr_en=0) and REQ (FIFO non-empty, wr_en=1).
- IDLE to REQ on push.
- REQ to IDLE on a pop that leaves the FIFO empty with no simultaneous push.

Verification
REQ-027 Stream 16 valid bits 1,0,1,0,... with wr_ready=1 -> wr_en=1 one cycle later, wr_addr=0, wr_data=16'h5555, overflow=0.
REQ-028 Full default frame of 24964 bits, all 1, wr_ready=1 -> 1561 accepted writes:
- addresses 0..1560;
- word 1560 = 16'h000F;
- frame_done pulses once, after the accept of word 1560.
REQ-029 wr_ready=0 for 40 cycles during continuous valid bits -> 2 words held with wr_addr/wr_data stable, third word lost, overflow=1 and stays 1; the address still advances.
REQ-030 edge_valid toggling every other cycle, wr_ready toggling -> every word is accepted in address order with no loss and overflow=0.
REQ-031 Assert rst after 100 bits of a frame, then send 16 bits of 1 -> write at addr 0 with 16'hFFFF; no stale word is written.
REQ-032 Two back-to-back default frames -> second frame restarts at addr 0; frame_done pulses exactly twice.
